// File: rtl/sd_sector_arb.sv
// Round-robin arbiter between two virtual-disk clients and the single SD sector port.
// It latches requests, runs the sd_ack handshake with a timeout, routes buffer strobes and tracks mounts.
module sd_sector_arb #(
  parameter int TO_BITS = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  cl_rd,
  input  logic [1:0]  cl_wr,
  input  logic [31:0] cl_lba0,
  input  logic [31:0] cl_lba1,
  output logic [1:0]  cl_busy,
  output logic [1:0]  cl_done,
  output logic [1:0]  cl_err,
  output logic [1:0]  cl_buff_wr,
  input  logic [7:0]  cl_buff_din0,
  input  logic [7:0]  cl_buff_din1,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  output logic [31:0] sd_lba,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  input  logic [1:0]  img_mounted,
  input  logic [31:0] img_size,
  output logic [1:0]  mounted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         dir_rd_q, dir_rd_d;
  logic [1:0][31:0]   lba_q, lba_d;
  logic [1:0][31:0]   cl_lba_s;
  logic [31:0]        sd_lba_q, sd_lba_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [1:0]         sd_rd_q, sd_rd_d;
  logic [1:0]         sd_wr_q, sd_wr_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         cerr_q, cerr_d;
  logic [1:0]         mounted_q, mounted_d;
  logic [TO_BITS-1:0] to_q, to_d;
  logic [TO_BITS-1:0] to_inc_s;
  logic [1:0]         grant_oh_s;
  logic               win_s;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  assign cl_lba_s   = {cl_lba1, cl_lba0};
  assign grant_oh_s = onehot(grant_q);
  assign to_inc_s   = to_q + {{(TO_BITS-1){1'b0}}, 1'b1};
  // With both pending, the client not served last wins.
  assign win_s      = (pend_q == 2'b11) ? ~last_q : ~pend_q[0];

  assign cl_busy     = pend_q | ((state_q != S_IDLE) ? grant_oh_s : 2'b00);
  assign cl_buff_wr  = (state_q == S_XFER && sd_buff_wr) ? grant_oh_s : 2'b00;
  assign sd_buff_din = (state_q != S_XFER) ? 8'h00 : (grant_q ? cl_buff_din1 : cl_buff_din0);
  assign cl_done     = done_q;
  assign cl_err      = cerr_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = sd_lba_q;
  assign mounted     = mounted_q;

  // Mount tracking is independent of the transfer in progress.
  always_comb begin
    mounted_d = mounted_q;
    for (int i = 0; i < 2; i++) begin
      if (img_mounted[i]) begin
        mounted_d[i] = (img_size != 32'd0);
      end else begin
        mounted_d[i] = mounted_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    dir_rd_d = dir_rd_q;
    lba_d    = lba_q;
    sd_lba_d = sd_lba_q;
    grant_d  = grant_q;
    last_d   = last_q;
    err_d    = err_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    to_d     = to_q;
    done_d   = 2'b00;
    cerr_d   = 2'b00;

    for (int i = 0; i < 2; i++) begin
      if (!cl_busy[i] && (cl_rd[i] || cl_wr[i])) begin
        pend_d[i]   = 1'b1;
        dir_rd_d[i] = cl_rd[i];
        lba_d[i]    = cl_lba_s[i];
      end else begin
        pend_d[i]   = pend_q[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          grant_d        = win_s;
          pend_d[win_s]  = 1'b0;
          if (mounted_q[win_s]) begin
            state_d  = S_REQ;
            sd_lba_d = lba_q[win_s];
            sd_rd_d  = dir_rd_q[win_s] ? onehot(win_s) : 2'b00;
            sd_wr_d  = dir_rd_q[win_s] ? 2'b00 : onehot(win_s);
            to_d     = {TO_BITS{1'b0}};
            err_d    = 1'b0;
          end else begin
            state_d  = S_DONE;
            err_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          state_d = S_XFER;
          sd_rd_d = 2'b00;
          sd_wr_d = 2'b00;
        end else if (to_inc_s == {TO_BITS{1'b1}}) begin
          state_d = S_DONE;
          sd_rd_d = 2'b00;
          sd_wr_d = 2'b00;
          err_d   = 1'b1;
          to_d    = to_inc_s;
        end else begin
          to_d    = to_inc_s;
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end else begin
          state_d = S_XFER;
        end
      end
      S_DONE: begin
        done_d  = grant_oh_s;
        cerr_d  = err_q ? grant_oh_s : 2'b00;
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        sd_rd_d = 2'b00;
        sd_wr_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pend_q    <= 2'b00;
      dir_rd_q  <= 2'b00;
      lba_q     <= '0;
      sd_lba_q  <= 32'd0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      sd_rd_q   <= 2'b00;
      sd_wr_q   <= 2'b00;
      to_q      <= {TO_BITS{1'b0}};
      done_q    <= 2'b00;
      cerr_q    <= 2'b00;
      mounted_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      dir_rd_q  <= dir_rd_d;
      lba_q     <= lba_d;
      sd_lba_q  <= sd_lba_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      err_q     <= err_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      to_q      <= to_d;
      done_q    <= done_d;
      cerr_q    <= cerr_d;
      mounted_q <= mounted_d;
    end
  end

endmodule
